// File: rtl/pipe_pattern_gen.sv
// Pipe column source: alternates SPACING blank columns with PIPE_W columns of a pipe whose
// GAP_H-row opening sits at an LFSR-chosen height; outputs are registered, one column per advance.
module pipe_pattern_gen #(
  parameter logic [7:0] SEED    = 8'hA5,
  parameter int         GAP_H   = 3,
  parameter int         SPACING = 4,
  parameter int         PIPE_W  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       active,
  input  logic       gameover,
  input  logic       advance,
  output logic [7:0] newPattern,
  output logic       newPipe,
  output logic [7:0] pipeCount
);

  localparam int MAXC = (SPACING > PIPE_W) ? SPACING : PIPE_W;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] SPACE_LAST = CW'(SPACING - 1);
  localparam logic [CW-1:0] PIPE_LAST  = CW'(PIPE_W - 1);
  localparam logic [2:0]    MAXPOS     = 3'(8 - GAP_H);
  localparam logic [2:0]    WRAP_SUB   = 3'(9 - GAP_H);
  localparam logic [7:0]    GAP_MASK   = 8'((1 << GAP_H) - 1);

  typedef enum logic [1:0] {IDLE, SPACE, PIPE, FROZEN} state_t;

  state_t        state_q;
  logic [7:0]    lfsr_q;
  logic [CW-1:0] col_cnt_q;
  logic [7:0]    pattern_q;
  logic          new_pipe_q;
  logic [7:0]    pipe_cnt_q;

  logic [7:0]    lfsr_d;
  logic [2:0]    pos_d;
  logic [7:0]    pipe_d;

  // Opening position comes from the pre-step LFSR value, folded into the legal row range.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    pos_d  = (lfsr_q[2:0] > MAXPOS) ? (lfsr_q[2:0] - WRAP_SUB) : lfsr_q[2:0];
    pipe_d = ~(GAP_MASK << pos_d);
  end

  always_ff @(posedge clk) begin
    if (reset || !active) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED;
      col_cnt_q  <= '0;
      pattern_q  <= 8'h00;
      new_pipe_q <= 1'b0;
      pipe_cnt_q <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= SPACE;
          new_pipe_q <= 1'b0;
        end
        SPACE, PIPE: begin
          new_pipe_q <= 1'b0;
          if (gameover) begin
            state_q <= FROZEN;
          end else if (advance) begin
            lfsr_q <= lfsr_d;
            if (state_q == SPACE) begin
              if (col_cnt_q == SPACE_LAST) begin
                state_q    <= PIPE;
                col_cnt_q  <= '0;
                pattern_q  <= pipe_d;
                new_pipe_q <= 1'b1;
                if (pipe_cnt_q != 8'hFF) begin
                  pipe_cnt_q <= pipe_cnt_q + 8'd1;
                end
              end else begin
                col_cnt_q <= col_cnt_q + CW'(1);
              end
            end else begin
              if (col_cnt_q == PIPE_LAST) begin
                state_q   <= SPACE;
                col_cnt_q <= '0;
                pattern_q <= 8'h00;
              end else begin
                col_cnt_q <= col_cnt_q + CW'(1);
              end
            end
          end
        end
        FROZEN: begin
          new_pipe_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign newPattern = pattern_q;
  assign newPipe    = new_pipe_q;
  assign pipeCount  = pipe_cnt_q;

endmodule
